// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter sharing one register-file write port
module regfile_write_arbiter #(
  parameter int SEL_BITS = 3,
  parameter int BIT_SIZE = 16,
  parameter int NUM_REQ  = 3,
  parameter int ID_BITS  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         hold,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*SEL_BITS-1:0]  req_dr,
  input  logic [NUM_REQ*BIT_SIZE-1:0]  req_data,
  output logic                         rf_we,
  output logic [SEL_BITS-1:0]          rf_DR,
  output logic [BIT_SIZE-1:0]          rf_data,
  output logic [ID_BITS-1:0]           grant_id,
  output logic [(1<<SEL_BITS)-1:0]     pending,
  output logic [15:0]                  write_count
);

  localparam logic [ID_BITS:0]   NREQ_W = (ID_BITS+1)'(NUM_REQ);
  localparam logic [ID_BITS-1:0] LAST_ID = ID_BITS'(NUM_REQ - 1);

  logic [ID_BITS-1:0]  ptr;
  logic [ID_BITS-1:0]  winner;
  logic                grant;
  logic [SEL_BITS-1:0] win_dr;
  logic [BIT_SIZE-1:0] win_data;

  // Scan from ptr, wrapping modulo NUM_REQ; first valid requester wins.
  always_comb begin
    logic [ID_BITS:0] sum;
    logic             found;
    sum    = '0;
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (ID_BITS+1)'(k);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      if (!found && req_valid[sum[ID_BITS-1:0]]) begin
        found  = 1'b1;
        winner = sum[ID_BITS-1:0];
      end
    end
    grant = found && !hold && !reset;
  end

  always_comb begin
    win_dr   = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_BITS'(i)) begin
        win_dr   = req_dr[i*SEL_BITS +: SEL_BITS];
        win_data = req_data[i*BIT_SIZE +: BIT_SIZE];
      end
    end
  end

  assign req_ready = grant ? (NUM_REQ'(1) << winner) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we       <= 1'b0;
      rf_DR       <= '0;
      rf_data     <= '0;
      grant_id    <= '0;
      ptr         <= '0;
      write_count <= '0;
    end else if (grant) begin
      rf_we    <= 1'b1;
      rf_DR    <= win_dr;
      rf_data  <= win_data;
      grant_id <= winner;
      ptr      <= (winner == LAST_ID) ? '0 : winner + 1'b1;
      if (write_count != 16'hFFFF) write_count <= write_count + 16'd1;
    end else begin
      rf_we <= 1'b0;
    end
  end

  // Decoded from the registered stage so it tracks exactly what the register file sees.
  always_comb begin
    pending = '0;
    if (rf_we) pending[rf_DR] = 1'b1;
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - scoreboard bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  logic        clk;
  logic        reset;
  logic        hold;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [8:0]  req_dr;
  logic [47:0] req_data;
  logic        rf_we;
  logic [2:0]  rf_DR;
  logic [15:0] rf_data;
  logic [1:0]  grant_id;
  logic [7:0]  pending;
  logic [15:0] write_count;

  regfile_write_arbiter #(
    .SEL_BITS(3), .BIT_SIZE(16), .NUM_REQ(3), .ID_BITS(2)
  ) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dr(req_dr), .req_data(req_data),
    .rf_we(rf_we), .rf_DR(rf_DR), .rf_data(rf_data),
    .grant_id(grant_id), .pending(pending), .write_count(write_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  dr;
    logic [15:0] data;
    logic [1:0]  id;
  } wr_t;

  wr_t         sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          m_ptr  = 0;
  logic [15:0] m_cnt  = 16'd0;
  logic [2:0]  dr_in  [3];
  logic [15:0] data_in[3];
  logic [15:0] rf_mem [8];

  // Register file fed by the DUT output stage; reset also suppresses its write.
  always @(posedge clk) begin
    if (rf_we && !reset) rf_mem[rf_DR] <= rf_data;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int model_winner(input logic [2:0] v, input int p);
    for (int k = 0; k < 3; k++) begin
      if (v[(p + k) % 3]) return (p + k) % 3;
    end
    return -1;
  endfunction

  task automatic check_outputs();
    wr_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq("rf_we", rf_we, 1);
      check_eq("rf_DR", rf_DR, e.dr);
      check_eq("rf_data", rf_data, e.data);
      check_eq("grant_id", grant_id, e.id);
      check_eq("pending", pending, 32'd1 << e.dr);
    end else begin
      check_eq("rf_we_idle", rf_we, 0);
      check_eq("pending_idle", pending, 0);
    end
    check_eq("write_count", write_count, m_cnt);
  endtask

  // One clock cycle: drive, check at negedge, advance the model at the edge.
  task automatic cycle(input logic [2:0] v, input logic h, input logic r);
    int   w;
    logic [2:0] exp_ready;
    wr_t  e;
    req_valid = v;
    hold      = h;
    reset     = r;
    req_dr    = {dr_in[2], dr_in[1], dr_in[0]};
    req_data  = {data_in[2], data_in[1], data_in[0]};
    @(negedge clk);
    check_outputs();
    w = model_winner(v, m_ptr);
    exp_ready = (r || h || w < 0) ? 3'b000 : (3'b001 << w);
    check_eq("req_ready", req_ready, exp_ready);
    @(posedge clk);
    if (r) begin
      sb_q.delete();
      m_ptr = 0;
      m_cnt = 16'd0;
    end else if (exp_ready != 3'b000) begin
      e.dr   = dr_in[w];
      e.data = data_in[w];
      e.id   = 2'(w);
      sb_q.push_back(e);
      m_ptr = (w + 1) % 3;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0; req_valid = '0; req_dr = '0; req_data = '0;
    for (int i = 0; i < 8; i++) rf_mem[i] = 16'h0;
    for (int i = 0; i < 3; i++) begin dr_in[i] = 3'(i); data_in[i] = 16'h1000 + 16'(i); end

    cycle(3'b000, 0, 1);
    cycle(3'b111, 1, 1);
    check_eq("rst_rf_DR", rf_DR, 0);
    check_eq("rst_rf_data", rf_data, 0);
    check_eq("rst_grant_id", grant_id, 0);

    // Single requester 1 writes R5.
    dr_in[1] = 3'd5; data_in[1] = 16'h1234;
    cycle(3'b010, 0, 0);
    cycle(3'b000, 0, 0);
    check_eq("rd_before_vis", rf_mem[5], 16'h1234);
    cycle(3'b000, 0, 0);
    check_eq("r5_read", rf_mem[5], 16'h1234);

    // Fair rotation then hold.
    cycle(3'b000, 0, 1);
    for (int i = 0; i < 3; i++) begin dr_in[i] = 3'(i + 1); data_in[i] = 16'hA000 + 16'(i); end
    for (int i = 0; i < 6; i++) begin
      cycle(3'b111, 0, 0);
    end
    check_eq("cnt6", write_count, 16'd6);
    cycle(3'b111, 1, 0);
    check_eq("hold_drain_done", rf_we, 0);
    cycle(3'b111, 1, 0);
    cycle(3'b111, 1, 0);
    req_valid = 3'b111; hold = 1'b0;
    #1 check_eq("resume_ptr", req_ready, 3'b001);
    cycle(3'b111, 0, 0);
    cycle(3'b000, 0, 0);

    // Same DR back-to-back: last grant wins.
    cycle(3'b000, 0, 1);
    dr_in[0] = 3'd2; data_in[0] = 16'h0001;
    dr_in[2] = 3'd2; data_in[2] = 16'h00FF;
    cycle(3'b001, 0, 0);
    cycle(3'b100, 0, 0);
    check_eq("pend2_b2b", pending, 8'b0000_0100);
    cycle(3'b000, 0, 0);
    cycle(3'b000, 0, 0);
    check_eq("r2_last_wins", rf_mem[2], 16'h00FF);

    // Reset while a write sits in the output stage.
    cycle(3'b000, 0, 1);
    dr_in[1] = 3'd6; data_in[1] = 16'hBEEF;
    cycle(3'b010, 0, 0);
    cycle(3'b000, 0, 1);
    cycle(3'b000, 0, 0);
    check_eq("r6_discarded", rf_mem[6], 16'h0);
    check_eq("cnt_after_rst", write_count, 16'd0);
    cycle(3'b111, 0, 0);
    cycle(3'b000, 0, 0);

    // Saturating write counter.
    cycle(3'b000, 0, 1);
    dr_in[0] = 3'd3; data_in[0] = 16'h5555;
    for (int i = 0; i < 65535; i++) cycle(3'b001, 0, 0);
    check_eq("cnt_ffff", write_count, 16'hFFFF);
    dr_in[0] = 3'd7; data_in[0] = 16'hA5A5;
    cycle(3'b001, 0, 0);
    cycle(3'b000, 0, 0);
    check_eq("cnt_sat", write_count, 16'hFFFF);
    check_eq("r7_sat_write", rf_mem[7], 16'hA5A5);
    cycle(3'b000, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
